mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_sign_fix.sv | 26 ++
 rtl/mult_div_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared types for the multiply/divide unit: operation encoding,
//            FSM state enumeration and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  // Operation select as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// ============================================================================
// Module   : mdu_sign_fix
// Purpose  : Conditional two's-complement negate. Used both to turn signed
//            operands into magnitudes and to re-apply result signs.
// Ports    : val_i - input value
//            neg_i - 1: output is -val_i, 0: output is val_i
//            res_o - conditioned value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is required.
  assign res_o = neg_i ? (~val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative MIPS-style HI/LO multiply/divide unit. One iteration
//            per clock (shift-add multiply, restoring divide) on operand
//            magnitudes, with sign correction applied in a final cycle.
// Ports    : clk, rst            - clock, async active-high reset
//            start, op, a, b     - operation request (accepted in IDLE only)
//            hi_we, lo_we, wdata - direct HI/LO writes (IDLE only)
//            busy, done          - in-progress flag, one-cycle completion
//            div_by_zero         - valid with done; divisor was zero
//            hi, lo              - architectural HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // product high half / remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier bits / quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand / divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;         // product / quotient sign
  logic               rem_neg_q, rem_neg_d; // remainder sign
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               dzo_q, dzo_d;

  op_e                op_sel;
  logic               start_ok;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ok;

  assign op_sel   = op_e'(op);
  assign start_ok = (state_q == IDLE) && start;
  assign a_neg    = op_is_signed(op_sel) && a[WIDTH-1];
  assign b_neg    = op_is_signed(op_sel) && b[WIDTH-1];

  // Operand conditioning.
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.val_i(a), .neg_i(a_neg), .res_o(a_mag));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.val_i(b), .neg_i(b_neg), .res_o(b_mag));

  // Result correction.
  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .val_i({acc_hi_q, acc_lo_q}), .neg_i(neg_q), .res_o(prod_fix)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.val_i(acc_lo_q), .neg_i(neg_q),     .res_o(quo_fix));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.val_i(acc_hi_q), .neg_i(rem_neg_q), .res_o(rem_fix));

  // Multiply step: add multiplicand when the current multiplier LSB is set,
  // then shift the {acc_hi, acc_lo} pair right, carry entering the top.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide step: shift the next dividend bit into the partial remainder and
  // keep the difference only when it does not go negative. When it does fit,
  // the true difference is below the divisor, so the low WIDTH bits suffice.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST_ITER) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    dzo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          acc_hi_d  = '0;
          acc_lo_d  = a_mag;
          opnd_d    = b_mag;
          cnt_d     = '0;
          is_div_d  = op_is_div(op_sel);
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dz_d      = op_is_div(op_sel) && (b == '0);
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_hi_d = div_ok ? div_diff : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      FIN: begin
        done_d = 1'b1;
        dzo_d  = dz_q;
        // A zero divisor leaves HI/LO untouched; only the flag reports it.
        if (!dz_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dzo_q     <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dzo_q     <= dzo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dzo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire
